valve_scheduler: RTL

- Shares one water supply between N_ZONES sensor-driven valves.
- Each zone raises a level-sensitive sensor request. The scheduler grants zones round-robin, opens one valve for a fixed dose, then enforces a rest period before the next grant.
- Sits above the per-zone valve sequencers. At most one valve is ever open.

---
 rtl/valve_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/valve_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : valve_scheduler
//  Description : Round-robin arbiter sharing one water supply among N_ZONES
//                sensor-driven valves. Grants one zone at a time for a fixed
//                dose of OPEN_CYC cycles, then holds all valves closed for
//                REST_CYC cycles before the next grant.
//                Optional macro VALVE_SCHED_EXTEND_EN enables up to MAX_EXT
//                dose extensions while the granted zone keeps requesting.
//  Revision    : 1.0  initial release
// ============================================================================
module valve_scheduler #(
  parameter int N_ZONES  = 4,
  parameter int ZW       = 2,
  parameter int OPEN_CYC = 8,
  parameter int REST_CYC = 2,
  parameter int MAX_EXT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_ZONES-1:0] sensor,
  output logic [N_ZONES-1:0] valve,
  output logic [ZW-1:0]      zone,
  output logic               busy,
  output logic               done
);

  // One shared down-counter serves both OPEN and REST, so it is sized for the longer phase.
  localparam int c_cnt_max = (OPEN_CYC > REST_CYC) ? OPEN_CYC : REST_CYC;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_open_ld = c_cnt_w'(OPEN_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_rest_ld = c_cnt_w'(REST_CYC - 1);
  localparam logic [N_ZONES-1:0] c_one     = N_ZONES'(1);
  localparam logic [ZW-1:0]      c_last    = ZW'(N_ZONES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_REST = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic [N_ZONES-1:0]   r_valve, w_valve_nxt;
  logic [ZW-1:0]        r_zone, w_zone_nxt;
  logic [ZW-1:0]        r_ptr, w_ptr_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;

  logic                 w_found;
  logic [ZW-1:0]        w_sel;
  logic [ZW-1:0]        w_zone_inc;

`ifdef VALVE_SCHED_EXTEND_EN
  localparam int c_ext_w = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;
  localparam logic [c_ext_w-1:0] c_ext_max = c_ext_w'(MAX_EXT);
  logic [c_ext_w-1:0]   r_ext, w_ext_nxt;
`else
  // Extension limit has no meaning without the extension logic.
  logic                 w_unused_max_ext;
  assign w_unused_max_ext = (MAX_EXT != 0);
`endif

  // Zone that just finished moves to lowest priority for the next scan.
  assign w_zone_inc = (r_zone == c_last) ? '0 : r_zone + 1'b1;

  // Scan requests upward from the round-robin pointer, wrapping at N_ZONES.
  always_comb begin : p_scan
    logic [ZW:0] sum;
    sum     = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      sum = {1'b0, r_ptr} + (ZW+1)'(i);
      if (sum >= (ZW+1)'(N_ZONES)) sum = sum - (ZW+1)'(N_ZONES);
      if (!w_found && sensor[sum[ZW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = sum[ZW-1:0];
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/OPEN/REST sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valve_nxt = r_valve;
    w_zone_nxt  = r_zone;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef VALVE_SCHED_EXTEND_EN
    w_ext_nxt   = r_ext;
`endif
    case (r_state)
      S_IDLE: begin
        w_valve_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (enable && w_found) begin
          w_state_nxt = S_OPEN;
          w_zone_nxt  = w_sel;
          w_valve_nxt = c_one << w_sel;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = c_open_ld;
`ifdef VALVE_SCHED_EXTEND_EN
          w_ext_nxt   = '0;
`endif
        end
      end
      S_OPEN: begin
        // Dose runs to completion regardless of the requesting sensor; only enable aborts it.
        if (enable && (r_cnt != '0)) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
`ifdef VALVE_SCHED_EXTEND_EN
        else if (enable && sensor[r_zone] && (r_ext < c_ext_max)) begin
          w_cnt_nxt = c_open_ld;
          w_ext_nxt = r_ext + 1'b1;
        end
`endif
        else begin
          w_state_nxt = S_REST;
          w_valve_nxt = '0;
          w_cnt_nxt   = c_rest_ld;
          w_done_nxt  = 1'b1;
          w_ptr_nxt   = w_zone_inc;
        end
      end
      S_REST: begin
        w_valve_nxt = '0;
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valve_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valve <= '0;
      r_zone  <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valve <= w_valve_nxt;
      r_zone  <= w_zone_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef VALVE_SCHED_EXTEND_EN
  // Extension count for the current grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ext <= '0;
    else      r_ext <= w_ext_nxt;
  end
`endif

  assign valve = r_valve;
  assign zone  = r_zone;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire
